// File: rtl/data_break_ctl_pkg.sv
// -----------------------------------------------------------------------------
// data_break_ctl_pkg
// Shared definitions for the PDP-8/E data-break controller: word and address
// widths, the break sequencer state encoding and a 12-bit increment helper.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package data_break_ctl_pkg;

    localparam int WORD_W  = 12;  // PDP-8 word
    localparam int ADDR_W  = 15;  // {field[2:0], addr[11:0]}
    localparam int FIELD_W = ADDR_W - WORD_W;

    // Break sequencer states. WC0..CA1 only appear in three-cycle breaks.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        WC0  = 3'd2,
        WC1  = 3'd3,
        CA0  = 3'd4,
        CA1  = 3'd5,
        DAT0 = 3'd6,
        DAT1 = 3'd7
    } brk_state_t;

    // 12-bit modulo increment; 7777 wraps to 0000 and never carries into field.
    function automatic logic [WORD_W-1:0] word_inc(input logic [WORD_W-1:0] w);
        return w + WORD_W'(1);
    endfunction

endpackage

// File: rtl/brk_prio_enc.sv
// -----------------------------------------------------------------------------
// brk_prio_enc
// Fixed-priority encoder for break requests. Index 0 has the highest priority.
//
// Ports:
//   req     in   N       request vector
//   onehot  out  N       one-hot winner (all zero when no request)
//   idx     out  IDX_W   binary index of the winner (0 when no request)
//   any     out  1       at least one request is set
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module brk_prio_enc #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the lowest priority upwards so the lowest set index is the
    // last assignment and therefore wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise the
        // paths where no bit matches would infer latches.
        onehot = '0;
        idx    = '0;
        any    = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/data_break_ctl.sv
// -----------------------------------------------------------------------------
// data_break_ctl
// Sequences PDP-8/E data-break (DMA) cycles between NREQ peripherals and core
// memory. A winning request is latched in IDLE, the CPU is asked to divert via
// brk_pending, and once the CPU reaches a break-safe point the controller owns
// the memory mux (brk_active) for either a single-cycle break (data only) or a
// three-cycle break (WC increment, CA increment, then data at {field, CA}).
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   cpu_safe      CPU is at a break-safe boundary this cycle
//   brk_pending   break queued; CPU must enter DB0 at next safe point
//   brk_active    controller owns memory; CPU holds
//   dev_req       level request per device
//   dev_three     per device: 1 = three-cycle break
//   dev_to_mem    per device: 1 = write memory, 0 = read memory
//   dev_addr      per device: 15-bit single-cycle address
//   dev_field     per device: data field for three-cycle transfers
//   dev_wc_ptr    per device: field-0 address of WC word (CA at +1)
//   dev_wdata     per device: write data
//   dev_grant     one-hot pulse when the request is latched
//   dev_done      one-hot pulse when the transfer completes
//   dev_rdata     read data, valid with dev_done
//   dev_wc_ovf    pulses with dev_done when WC incremented to 0000
//   mem_addr/mem_wdata/mem_re/mem_we/mem_rdata   memory port; read data
//                 arrives on mem_rdata the cycle after mem_re
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module data_break_ctl
    import data_break_ctl_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int WC_BASE_W = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_safe,
    output logic                      brk_pending,
    output logic                      brk_active,
    input  logic [NREQ-1:0]           dev_req,
    input  logic [NREQ-1:0]           dev_three,
    input  logic [NREQ-1:0]           dev_to_mem,
    input  logic [NREQ*ADDR_W-1:0]    dev_addr,
    input  logic [NREQ*FIELD_W-1:0]   dev_field,
    input  logic [NREQ*WC_BASE_W-1:0] dev_wc_ptr,
    input  logic [NREQ*WORD_W-1:0]    dev_wdata,
    output logic [NREQ-1:0]           dev_grant,
    output logic [NREQ-1:0]           dev_done,
    output logic [WORD_W-1:0]         dev_rdata,
    output logic                      dev_wc_ovf,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WORD_W-1:0]         mem_wdata,
    output logic                      mem_re,
    output logic                      mem_we,
    input  logic [WORD_W-1:0]         mem_rdata
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // -------------------------------------------------------------------------
    // Per-device views of the flattened request buses
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0]    req_addr  [NREQ];
    logic [FIELD_W-1:0]   req_field [NREQ];
    logic [WC_BASE_W-1:0] req_wcp   [NREQ];
    logic [WORD_W-1:0]    req_wdata [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_addr[g]  = dev_addr[g*ADDR_W +: ADDR_W];
        assign req_field[g] = dev_field[g*FIELD_W +: FIELD_W];
        assign req_wcp[g]   = dev_wc_ptr[g*WC_BASE_W +: WC_BASE_W];
        assign req_wdata[g] = dev_wdata[g*WORD_W +: WORD_W];
    end

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [NREQ-1:0]  win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;

    brk_prio_enc #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .req    (dev_req),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    // -------------------------------------------------------------------------
    // State and latched request
    // -------------------------------------------------------------------------
    brk_state_t           state_q, state_d;
    logic [NREQ-1:0]      sel_q;        // one-hot latched winner
    logic                 three_q;
    logic                 to_mem_q;
    logic [ADDR_W-1:0]    data_addr_q;  // final data address
    logic [FIELD_W-1:0]   field_q;
    logic [WC_BASE_W-1:0] wc_ptr_q;
    logic [WORD_W-1:0]    wdata_q;
    logic                 ovf_q;

    // Incremented memory word, used for both WC1 and CA1 write-back.
    logic [WORD_W-1:0]    rd_inc;
    logic [WC_BASE_W-1:0] ca_ptr;
    logic [ADDR_W-1:0]    wc_addr;
    logic [ADDR_W-1:0]    ca_addr;

    assign rd_inc  = word_inc(mem_rdata);
    assign ca_ptr  = wc_ptr_q + WC_BASE_W'(1);   // 7777 wraps to 0000
    assign wc_addr = ADDR_W'(wc_ptr_q);          // WC/CA live in field 0
    assign ca_addr = ADDR_W'(ca_ptr);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            // The latched payload is cleared along with the state so a reset
            // mid-break leaves no trace of the abandoned transfer.
            state_q     <= IDLE;
            sel_q       <= '0;
            three_q     <= 1'b0;
            to_mem_q    <= 1'b0;
            data_addr_q <= '0;
            field_q     <= '0;
            wc_ptr_q    <= '0;
            wdata_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        sel_q       <= win_onehot;
                        three_q     <= dev_three[win_idx];
                        to_mem_q    <= dev_to_mem[win_idx];
                        data_addr_q <= req_addr[win_idx];
                        field_q     <= req_field[win_idx];
                        wc_ptr_q    <= req_wcp[win_idx];
                        wdata_q     <= req_wdata[win_idx];
                        ovf_q       <= 1'b0;
                    end
                end
                WC1:     ovf_q       <= (rd_inc == '0);
                // Data address for a three-cycle break is the incremented CA
                // in the device's field; field bits never receive a carry.
                CA1:     data_addr_q <= {field_q, rd_inc};
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        brk_pending = 1'b0;
        brk_active  = 1'b0;
        dev_grant   = '0;
        dev_done    = '0;
        dev_rdata   = '0;
        dev_wc_ovf  = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Grant is suppressed under reset since nothing is latched then.
                if (win_any && !reset) begin
                    dev_grant = win_onehot;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                brk_pending = 1'b1;
                if (cpu_safe) begin
                    state_d = three_q ? WC0 : DAT0;
                end
            end
            WC0: begin
                brk_active = 1'b1;
                mem_addr   = wc_addr;
                mem_re     = 1'b1;
                state_d    = WC1;
            end
            WC1: begin
                brk_active = 1'b1;
                mem_addr   = wc_addr;
                mem_wdata  = rd_inc;
                mem_we     = 1'b1;
                state_d    = CA0;
            end
            CA0: begin
                brk_active = 1'b1;
                mem_addr   = ca_addr;
                mem_re     = 1'b1;
                state_d    = CA1;
            end
            CA1: begin
                brk_active = 1'b1;
                mem_addr   = ca_addr;
                mem_wdata  = rd_inc;
                mem_we     = 1'b1;
                state_d    = DAT0;
            end
            DAT0: begin
                brk_active = 1'b1;
                mem_addr   = data_addr_q;
                if (to_mem_q) begin
                    mem_wdata = wdata_q;
                    mem_we    = 1'b1;
                end else begin
                    mem_re    = 1'b1;
                end
                state_d = DAT1;
            end
            DAT1: begin
                brk_active = 1'b1;
                dev_done   = sel_q;
                dev_wc_ovf = ovf_q;
                if (!to_mem_q) begin
                    dev_rdata = mem_rdata;
                end
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_break_ctl.sv
`timescale 1ns/1ps

module tb_data_break_ctl;

    localparam int NREQ = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_safe;
    logic        brk_pending;
    logic        brk_active;
    logic [1:0]  dev_req;
    logic [1:0]  dev_three;
    logic [1:0]  dev_to_mem;
    logic [29:0] dev_addr;
    logic [5:0]  dev_field;
    logic [23:0] dev_wc_ptr;
    logic [23:0] dev_wdata;
    logic [1:0]  dev_grant;
    logic [1:0]  dev_done;
    logic [11:0] dev_rdata;
    logic        dev_wc_ovf;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [11:0] mem_rdata;

    data_break_ctl #(.NREQ(NREQ), .WC_BASE_W(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_safe    (cpu_safe),
        .brk_pending (brk_pending),
        .brk_active  (brk_active),
        .dev_req     (dev_req),
        .dev_three   (dev_three),
        .dev_to_mem  (dev_to_mem),
        .dev_addr    (dev_addr),
        .dev_field   (dev_field),
        .dev_wc_ptr  (dev_wc_ptr),
        .dev_wdata   (dev_wdata),
        .dev_grant   (dev_grant),
        .dev_done    (dev_done),
        .dev_rdata   (dev_rdata),
        .dev_wc_ovf  (dev_wc_ovf),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Core memory model: one-cycle read latency, bench preload port.
    logic [11:0] mem_model [0:32767] = '{default: 12'o0};
    logic        pl_en = 1'b0;
    logic [14:0] pl_addr = '0;
    logic [11:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem_model[pl_addr] <= pl_data;
        else if (mem_we) mem_model[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem_model[mem_addr];
    end

    int errors = 0;
    int checks = 0;
    int overlap = 0;
    bit mon_en = 1'b0;

    // Scoreboard of expected completions.
    typedef struct packed {
        logic [1:0]  done;
        logic        chk_rd;
        logic [11:0] rdata;
        logic        ovf;
    } sb_t;
    sb_t sb[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_re && mem_we) overlap++;
            if (dev_done !== 2'b00) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: dev_done=%b with nothing outstanding", dev_done);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    if (dev_done !== e.done || dev_wc_ovf !== e.ovf ||
                        (e.chk_rd && dev_rdata !== e.rdata)) begin
                        errors++;
                        $display("FAIL completion: got done=%b rdata=%o ovf=%b, expected done=%b rdata=%o ovf=%b",
                                 dev_done, dev_rdata, dev_wc_ovf, e.done, e.rdata, e.ovf);
                    end
                end
            end
        end
    end

    // Expected memory-side operations for the planned break:
    // {brk_active, mem_addr, mem_re, mem_we, mem_wdata}
    logic [29:0] ops [0:4];
    int          n_ops;

    task automatic poke(input logic [14:0] a, input logic [11:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic set_dev(input int d, input logic three, input logic to_mem,
                           input logic [14:0] addr, input logic [2:0] field,
                           input logic [11:0] wcp, input logic [11:0] wdata);
        dev_three[d]          = three;
        dev_to_mem[d]         = to_mem;
        dev_addr[d*15 +: 15]  = addr;
        dev_field[d*3 +: 3]   = field;
        dev_wc_ptr[d*12 +: 12] = wcp;
        dev_wdata[d*12 +: 12] = wdata;
    endtask

    // Build the expected op list and push the expected completion.
    task automatic plan_break(input int d);
        logic        three, to_mem;
        logic [14:0] addr, wc_a, ca_a, daddr;
        logic [2:0]  field;
        logic [11:0] wcp, wdata, ca_p, wc_n, ca_n, r;
        logic [1:0]  oh;
        sb_t         e;
        three  = dev_three[d];
        to_mem = dev_to_mem[d];
        addr   = dev_addr[d*15 +: 15];
        field  = dev_field[d*3 +: 3];
        wcp    = dev_wc_ptr[d*12 +: 12];
        wdata  = dev_wdata[d*12 +: 12];
        wc_a   = {3'b000, wcp};
        wc_n   = mem_model[wc_a] + 12'd1;
        ca_p   = wcp + 12'd1;
        ca_a   = {3'b000, ca_p};
        ca_n   = mem_model[ca_a] + 12'd1;
        daddr  = three ? {field, ca_n} : addr;
        n_ops  = 0;
        if (three) begin
            ops[0] = {1'b1, wc_a, 1'b1, 1'b0, 12'o0};
            ops[1] = {1'b1, wc_a, 1'b0, 1'b1, wc_n};
            ops[2] = {1'b1, ca_a, 1'b1, 1'b0, 12'o0};
            ops[3] = {1'b1, ca_a, 1'b0, 1'b1, ca_n};
            n_ops  = 4;
        end
        ops[n_ops] = to_mem ? {1'b1, daddr, 1'b0, 1'b1, wdata}
                            : {1'b1, daddr, 1'b1, 1'b0, 12'o0};
        n_ops++;
        r = mem_model[daddr];
        if (three && daddr == wc_a) r = wc_n;
        if (three && daddr == ca_a) r = ca_n;
        oh       = 2'b01 << d;
        e.done   = oh;
        e.chk_rd = !to_mem;
        e.rdata  = to_mem ? 12'o0 : r;
        e.ovf    = three && (wc_n == 12'o0);
        sb.push_back(e);
    endtask

    task automatic wait_grant(input logic [1:0] exp, input string name, output int waited);
        #1;
        waited = 0;
        while (dev_grant === 2'b00 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (dev_grant !== exp) begin
            errors++;
            $display("FAIL %s grant: got %b expected %b", name, dev_grant, exp);
        end
    endtask

    // Called at the grant cycle; holds WAIT for safe_delay cycles, raises
    // cpu_safe, then checks every break cycle through DAT1 and the IDLE after.
    task automatic run_break(input int d, input int safe_delay, input string name);
        logic [29:0] got;
        logic [1:0]  oh;
        oh = 2'b01 << d;
        for (int k = 0; k < safe_delay; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if ({brk_pending, brk_active} !== 2'b10) begin
                    errors++;
                    $display("FAIL %s wait: pending/active got %b expected 10", name, {brk_pending, brk_active});
                end
                dev_req[d] = 1'b0;
            end
        end
        cpu_safe = 1'b1;
        for (int i = 0; i < n_ops; i++) begin
            @(negedge clk);
            got = {brk_active, mem_addr, mem_re, mem_we, mem_wdata};
            checks++;
            if (got !== ops[i]) begin
                errors++;
                $display("FAIL %s op%0d: got act/addr/re/we/wd %b/%o/%b/%b/%o expected %b/%o/%b/%b/%o",
                         name, i, got[29], got[28:14], got[13], got[12], got[11:0],
                         ops[i][29], ops[i][28:14], ops[i][13], ops[i][12], ops[i][11:0]);
            end
            if (i == 0) cpu_safe = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({brk_active, brk_pending, dev_done} !== {1'b1, 1'b0, oh}) begin
            errors++;
            $display("FAIL %s done_cycle: active/pending/done got %b/%b/%b expected 1/0/%b",
                     name, brk_active, brk_pending, dev_done, oh);
        end
        @(negedge clk);
        checks++;
        if ({brk_active, brk_pending, mem_re, mem_we, mem_addr, mem_wdata} !== 31'd0) begin
            errors++;
            $display("FAIL %s idle_after: active=%b pending=%b re=%b we=%b addr=%o wdata=%o",
                     name, brk_active, brk_pending, mem_re, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic check_mem(input logic [14:0] a, input logic [11:0] exp, input string name);
        checks++;
        if (mem_model[a] !== exp) begin
            errors++;
            $display("FAIL %s: mem[%o] got %o expected %o", name, a, mem_model[a], exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({brk_pending, brk_active, dev_grant, dev_done, dev_rdata, dev_wc_ovf,
             mem_addr, mem_wdata, mem_re, mem_we} !== 48'd0) begin
            errors++;
            $display("FAIL %s: outputs not zero (pend=%b act=%b gnt=%b done=%b rd=%o ovf=%b addr=%o wd=%o re=%b we=%b)",
                     name, brk_pending, brk_active, dev_grant, dev_done, dev_rdata, dev_wc_ovf,
                     mem_addr, mem_wdata, mem_re, mem_we);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_safe = 1'b0; dev_req = '0; dev_three = '0; dev_to_mem = '0;
        dev_addr = '0; dev_field = '0; dev_wc_ptr = '0; dev_wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");
        mon_en = 1'b1;
    endtask

    task automatic test_single_write();
        int w;
        set_dev(0, 1'b0, 1'b1, 15'o12345, 3'd0, 12'o0, 12'o4321);
        dev_req[0] = 1'b1;
        wait_grant(2'b01, "single_write", w);
        plan_break(0);
        run_break(0, 3, "single_write");
        check_mem(15'o12345, 12'o4321, "single_write_mem");
    endtask

    task automatic test_single_read();
        int w;
        poke(15'o00100, 12'o5252);
        set_dev(1, 1'b0, 1'b0, 15'o00100, 3'd0, 12'o0, 12'o0);
        dev_req[1] = 1'b1;
        wait_grant(2'b10, "single_read", w);
        plan_break(1);
        run_break(1, 1, "single_read");
    endtask

    task automatic test_three_read();
        int w;
        poke(15'o00030, 12'o7776);
        poke(15'o00031, 12'o0177);
        poke(15'o20200, 12'o1111);
        poke(15'o20201, 12'o2222);
        set_dev(0, 1'b1, 1'b0, 15'o0, 3'd2, 12'o0030, 12'o0);
        dev_req[0] = 1'b1;
        wait_grant(2'b01, "three_read", w);
        plan_break(0);
        run_break(0, 2, "three_read");
        check_mem(15'o00030, 12'o7777, "three_read_wc");
        check_mem(15'o00031, 12'o0200, "three_read_ca");
        dev_req[0] = 1'b1;
        wait_grant(2'b01, "three_read_ovf", w);
        plan_break(0);
        run_break(0, 1, "three_read_ovf");
        check_mem(15'o00030, 12'o0000, "three_read_ovf_wc");
        check_mem(15'o00031, 12'o0201, "three_read_ovf_ca");
    endtask

    task automatic test_wrap();
        int w;
        poke(15'o07777, 12'o0000);
        poke(15'o00000, 12'o7777);
        set_dev(1, 1'b1, 1'b1, 15'o0, 3'd5, 12'o7777, 12'o0123);
        dev_req[1] = 1'b1;
        wait_grant(2'b10, "wrap", w);
        plan_break(1);
        run_break(1, 2, "wrap");
        check_mem(15'o07777, 12'o0001, "wrap_wc");
        check_mem(15'o00000, 12'o0000, "wrap_ca");
        check_mem(15'o50000, 12'o0123, "wrap_data");
    endtask

    task automatic test_contention();
        int w;
        set_dev(0, 1'b0, 1'b1, 15'o00300, 3'd0, 12'o0, 12'o0555);
        set_dev(1, 1'b0, 1'b1, 15'o00200, 3'd0, 12'o0, 12'o0777);
        dev_req = 2'b11;
        wait_grant(2'b01, "contention_first", w);
        plan_break(0);
        run_break(0, 2, "contention_first");
        // run_break returns in the IDLE cycle right after dev_done[0].
        wait_grant(2'b10, "contention_second", w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL contention_gap: second grant after %0d extra cycles, expected 0", w);
        end
        plan_break(1);
        run_break(1, 1, "contention_second");
        check_mem(15'o00300, 12'o0555, "contention_mem0");
        check_mem(15'o00200, 12'o0777, "contention_mem1");
    endtask

    task automatic test_reset_mid_break();
        int w;
        poke(15'o00040, 12'o0010);
        poke(15'o00041, 12'o0400);
        set_dev(0, 1'b1, 1'b0, 15'o0, 3'd1, 12'o0040, 12'o0);
        dev_req[0] = 1'b1;
        wait_grant(2'b01, "reset_mid", w);
        @(negedge clk);
        dev_req[0] = 1'b0;
        cpu_safe   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_safe = 1'b0;
        end
        checks++;
        if ({mem_re, mem_we, mem_addr} !== {1'b0, 1'b1, 15'o00041}) begin
            errors++;
            $display("FAIL reset_mid_ca1: re/we/addr got %b/%b/%o expected 0/1/00041", mem_re, mem_we, mem_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset_mid_after");
        repeat (3) @(negedge clk);
        check_all_zero("reset_mid_quiet");
        poke(15'o10500, 12'o6060);
        set_dev(1, 1'b0, 1'b0, 15'o10500, 3'd0, 12'o0, 12'o0);
        dev_req[1] = 1'b1;
        wait_grant(2'b10, "after_reset", w);
        plan_break(1);
        run_break(1, 2, "after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_three_read();
        test_wrap();
        test_contention();
        test_reset_mid_break();
        repeat (2) @(negedge clk);
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL re_we_exclusive: %0d cycles with both strobes, expected 0", overlap);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL outstanding: %0d completions never seen, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_break_ctl.md
Name: data_break_ctl

Overview:
- Sequences PDP-8/E data-break (DMA) cycles between up to NREQ peripherals and core memory; the RK8E disk is device 0.
- Requests the CPU state machine to divert into break states, owns the memory address/data mux while a break is active, and then hands memory back.
- Supports single-cycle breaks and three-cycle breaks. A three-cycle break does a word-count increment, then a current-address increment, then the data transfer.
- Sits between the device controllers, the state machine's DB0/DB1 path and the memory mux.

Parameters:
- NREQ, 2, number of break requesters; index 0 has the highest priority.
- WC_BASE_W, 12, width of the word-count pointer; the WC/CA pair always lives in field 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_safe  in  1  CPU is at a break-safe boundary this cycle (state machine in E3 or F0 exit)
- brk_pending  out  1  a break is queued; state machine must enter DB0 at the next safe point
- brk_active  out  1  controller owns memory; CPU holds
- dev_req  in  NREQ  level request per device
- dev_three  in  NREQ  1 = three-cycle break
- dev_to_mem  in  NREQ  1 = device writes memory, 0 = device reads memory
- dev_addr  in  NREQ*15  single-cycle address {field[2:0], addr[11:0]}
- dev_field  in  NREQ*3  data field used for three-cycle transfers
- dev_wc_ptr  in  NREQ*12  field-0 address of the WC word; CA word is at wc_ptr+1
- dev_wdata  in  NREQ*12  write data
- dev_grant  out  NREQ  one-hot, 1-cycle pulse when the request is latched
- dev_done  out  NREQ  one-hot, 1-cycle pulse when the transfer completes
- dev_rdata  out  12  data read for a device (valid while dev_done is high)
- dev_wc_ovf  out  1  pulse with dev_done when WC incremented to 0000
- mem_addr  out  15  memory address
- mem_wdata  out  12  memory write data
- mem_re  out  1  read strobe; data valid on mem_rdata the next cycle
- mem_we  out  1  write strobe
- mem_rdata  in  12  memory read data

Behaviour:
- Reset: state IDLE. All outputs 0. The latched winner is cleared. Reset mid-break abandons the transfer with no done pulse; the device must re-request.

States:
- IDLE
  - If any dev_req bit is set, pick the lowest set index.
  - Latch that device's dev_three, dev_to_mem, addr, field, wc_ptr and wdata.
  - Pulse dev_grant, go to WAIT.
  - Requests dropped after the grant are ignored.
- WAIT
  - brk_pending=1.
  - On cpu_safe, go to WC0 if three-cycle, else DAT0.
- WC0
  - brk_active=1, mem_addr={3'b000, wc_ptr}, mem_re=1.
- WC1
  - wc_n = mem_rdata + 1, modulo 4096.
  - Write wc_n back to the same address (mem_we=1).
  - Set ovf flag if wc_n==0.
- CA0
  - mem_addr={000, wc_ptr+1}, with wc_ptr+1 wrapping 7777 to 0000.
  - mem_re=1.
- CA1
  - ca_n = mem_rdata + 1, modulo 4096.
  - Write ca_n back (mem_we=1).
  - Data address = {field, ca_n}.
- DAT0
  - If to_mem: mem_we=1, mem_wdata=latched wdata.
  - Else: mem_re=1.
- DAT1
  - If it was a read, dev_rdata = mem_rdata.
  - Pulse dev_done[sel]; pulse dev_wc_ovf if the flag is set.
  - Go to IDLE. brk_active drops next cycle.

Common rules:
- brk_active is 1 in every state from WC0/DAT0 through DAT1; brk_pending is 1 only in WAIT.
- Latency from cpu_safe to dev_done:
  - single-cycle break: 2 cycles;
  - three-cycle break: 6 cycles.
- Arbitration is fixed priority, re-evaluated only in IDLE. IDLE lasts at least 1 cycle between breaks, so the CPU can progress.
- Simultaneous requests: the lowest index wins. The loser keeps dev_req high and is granted after the winner's done.
- Address arithmetic is 12-bit modulo. Field bits never carry.
- mem_re and mem_we are never asserted together.
- mem_* outputs are 0 outside break states.

Decomposition:
- Shared package, alongside the existing state encodings parameter file: break state encodings (IDLE, WAIT, WC0, WC1, CA0, CA1, DAT0, DAT1) and WORD_W=12 / ADDR_W=15.
- Sub-module: brk_prio_enc, an NREQ-bit fixed-priority one-hot/index encoder.

Test Plan:
- Single-cycle write: dev0 req, to_mem=1, addr=1_2345, wdata=4321, cpu_safe 3 cycles after grant.
  - mem_we at addr 12345 with 4321 the cycle after cpu_safe; dev_done[0] the next cycle.
- Single-cycle read: memory 0_0100=5252, dev1 reads.
  - dev_rdata=5252 with dev_done[1], exactly 2 cycles after cpu_safe.
- Three-cycle read: wc_ptr=0030, mem[30]=7776, mem[31]=0177, field=2, mem[2_0200]=1111.
  - Memory after: mem[30]=7777, mem[31]=0200.
  - dev_rdata=1111, no ovf.
  - Repeat: mem[30]=0000, dev_wc_ovf pulses.
- Wrap: wc_ptr=7777, mem[7777]=0000, mem[0000]=7777.
  - CA read at 0000, CA written 0000, data address {field,0000}.
- Contention: dev0 and dev1 both request in the same cycle.
  - dev_grant[0] first; dev_grant[1] one IDLE cycle after dev_done[0].
- Reset in CA1 of a three-cycle break.
  - Next cycle: all outputs 0, state IDLE, no dev_done.
  - A fresh request completes normally.
